bus_arb2: RTL and testbench

- Two-master to one-slave arbiter for the codebase's req/ack/resp memory bus. Sits directly upstream of one port of the dual-port RAM wrapper (bus0 or bus1).
- Lets two requesters share one RAM port, for example a CPU data port and a DMA/matrix engine.
- Arbitrates round-robin with a grant lock, and returns in-order read responses to the master that issued each read, using a tag FIFO.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_arb_tagfifo.sv | 68 ++++++
 rtl/bus_arb2.sv | 130 +++++++++++++
 tb/tb_bus_arb2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the req/ack/resp memory bus.
// Holds the master ID type and its constants, plus the default bus field
// widths used by the arbiter and its tag FIFO.
package bus_pkg;

  // One bit is enough to name either master of a two-way arbiter.
  typedef logic mst_t;

  localparam mst_t MST0 = 1'b0;
  localparam mst_t MST1 = 1'b1;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DAT_W  = 32;
  localparam int BUS_BE_W   = BUS_DAT_W / 8;

endpackage

// File: rtl/bus_arb_tagfifo.sv
// Tag FIFO for the two-master arbiter.
// Records which master issued each accepted read so that in-order responses
// from the slave can be steered back to the right requester.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low clear (flushes all entries)
//   push   - write din at the tail (ignored when full)
//   pop    - drop the head entry (ignored when empty)
//   din    - master ID to record
//   dout   - master ID at the head
//   full   - DEPTH entries held
//   empty  - no entries held
module bus_arb_tagfifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic pop,
  input  mst_t din,
  output mst_t dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  mst_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  // One bit wider than the pointers so that full and empty are distinct.
  logic [PW:0]   count_reg;

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign dout  = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no clear: entries are only read when count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/bus_arb2.sv
// Two-master to one-slave arbiter for the req/ack/resp memory bus.
// Round-robin grant with a lock that holds the command stable while the
// slave stalls; read responses are returned in order to the issuing master
// using a tag FIFO. Commands pass through combinationally.
// Ports:
//   clk_i, rst_i                 - clock and asynchronous active-low reset
//   mX_req_i, mX_we_i            - master X request and write strobe
//   mX_addr_bi/be_bi/wdata_bi    - master X command fields
//   mX_ack_o                     - master X command accepted this cycle
//   mX_resp_o, mX_rdata_bo       - master X read data valid and data
//   s_req_o, s_we_o              - slave request and write strobe
//   s_addr_bo/be_bo/wdata_bo     - slave command fields (granted master)
//   s_ack_i                      - slave accepted the command
//   s_resp_i, s_rdata_bi         - slave read data valid and data
module bus_arb2
  import bus_pkg::*;
#(
  parameter int TAG_DEPTH = 4,
  parameter int ADDR_W    = BUS_ADDR_W,
  parameter int DAT_W     = BUS_DAT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_bi,
  input  logic [DAT_W/8-1:0] m0_be_bi,
  input  logic [DAT_W-1:0]  m0_wdata_bi,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [DAT_W-1:0]  m0_rdata_bo,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_bi,
  input  logic [DAT_W/8-1:0] m1_be_bi,
  input  logic [DAT_W-1:0]  m1_wdata_bi,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [DAT_W-1:0]  m1_rdata_bo,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_bo,
  output logic [DAT_W/8-1:0] s_be_bo,
  output logic [DAT_W-1:0]  s_wdata_bo,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DAT_W-1:0]  s_rdata_bi
);

  logic [1:0] req;
  logic [1:0] we;
  logic [1:0] elig;

  mst_t rr_reg;
  logic lock_reg;
  mst_t owner_reg;
  logic err_q;

  mst_t gnt;
  logic ack_hit;
  logic tag_full;
  logic tag_empty;
  logic tag_push;
  logic tag_pop;
  mst_t tag_head;

  assign req = {m1_req_i, m0_req_i};
  assign we  = {m1_we_i, m0_we_i};

  // A read is not eligible while the tag FIFO is full; writes always are.
  // Masking here (before the grant choice) lets the other master's write
  // through instead of stalling behind a read that cannot be tracked.
  assign elig[0] = req[0] && (we[0] || !tag_full);
  assign elig[1] = req[1] && (we[1] || !tag_full);

  always_comb begin
    gnt = rr_reg;
    if (lock_reg)        gnt = owner_reg;
    else if (elig[rr_reg])  gnt = rr_reg;
    else if (elig[~rr_reg]) gnt = ~rr_reg;
  end

  // Outputs are forced to zero while reset is held, independent of the clock.
  assign s_req_o    = rst_i && elig[gnt];
  assign s_we_o     = rst_i && we[gnt];
  assign s_addr_bo  = !rst_i ? '0 : (gnt == MST1) ? m1_addr_bi  : m0_addr_bi;
  assign s_be_bo    = !rst_i ? '0 : (gnt == MST1) ? m1_be_bi    : m0_be_bi;
  assign s_wdata_bo = !rst_i ? '0 : (gnt == MST1) ? m1_wdata_bi : m0_wdata_bi;

  assign ack_hit  = s_req_o && s_ack_i;
  assign m0_ack_o = ack_hit && (gnt == MST0);
  assign m1_ack_o = ack_hit && (gnt == MST1);

  assign tag_push = ack_hit && !we[gnt];
  assign tag_pop  = rst_i && s_resp_i && !tag_empty;

  assign m0_resp_o   = tag_pop && (tag_head == MST0);
  assign m1_resp_o   = tag_pop && (tag_head == MST1);
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  bus_arb_tagfifo #(.DEPTH(TAG_DEPTH)) u_tagfifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (gnt),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // The lock follows "request shown but not accepted": it drops on an ack,
  // and also when the owner withdraws its request (s_req_o falls).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_reg    <= MST0;
      lock_reg  <= 1'b0;
      owner_reg <= MST0;
      err_q     <= 1'b0;
    end else begin
      lock_reg  <= s_req_o && !s_ack_i;
      owner_reg <= gnt;
      if (ack_hit) rr_reg <= ~gnt;
      // A response with nothing outstanding cannot be routed; remember it.
      if (s_resp_i && tag_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
module tb_bus_arb2;

  localparam int TAG_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
  logic [31:0] m0_addr_bi = 0, m1_addr_bi = 0, m0_wdata_bi = 0, m1_wdata_bi = 0;
  logic [3:0]  m0_be_bi = 0, m1_be_bi = 0;
  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i = 0, s_resp_i = 0;
  logic [31:0] s_rdata_bi = 0;

  int checks = 0;
  int errors = 0;

  bus_arb2 #(.TAG_DEPTH(TAG_DEPTH), .ADDR_W(32), .DAT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
    .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi),
    .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
    .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi),
    .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
    .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
    .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_rr;         // preferred master
  bit m_lock;
  int m_owner;
  int m_q[$];       // IDs of outstanding reads, oldest first
  bit m_err;

  always @(negedge clk) begin
    int g;
    bit pend[2];
    bit exp_sreq, ack, has;
    int head, wg;
    logic [31:0] ea, ed;
    logic [3:0] eb;
    if (!rst_i) begin
      m_rr = 0; m_lock = 0; m_owner = 0; m_q.delete(); m_err = 0;
    end else begin
      pend[0] = m0_req_i && (m0_we_i || m_q.size() < TAG_DEPTH);
      pend[1] = m1_req_i && (m1_we_i || m_q.size() < TAG_DEPTH);
      if (m_lock) g = m_owner;
      else if (pend[m_rr]) g = m_rr;
      else if (pend[1-m_rr]) g = 1 - m_rr;
      else g = m_rr;
      exp_sreq = pend[g];
      ea = (g == 1) ? m1_addr_bi : m0_addr_bi;
      eb = (g == 1) ? m1_be_bi : m0_be_bi;
      ed = (g == 1) ? m1_wdata_bi : m0_wdata_bi;
      wg = (g == 1) ? int'(m1_we_i) : int'(m0_we_i);
      ack = exp_sreq && s_ack_i;
      has = s_resp_i && (m_q.size() > 0);
      head = has ? m_q[0] : 0;
      chk("s_req", s_req_o, exp_sreq);
      chk("s_we", s_we_o, wg[0]);
      chk("s_addr", s_addr_bo, ea);
      chk("s_be", s_be_bo, eb);
      chk("s_wdata", s_wdata_bo, ed);
      chk("m0_ack", m0_ack_o, ack && g == 0);
      chk("m1_ack", m1_ack_o, ack && g == 1);
      chk("m0_resp", m0_resp_o, has && head == 0);
      chk("m1_resp", m1_resp_o, has && head == 1);
      chk("m0_rdata", m0_rdata_bo, (has && head == 0) ? s_rdata_bi : 32'h0);
      chk("m1_rdata", m1_rdata_bo, (has && head == 1) ? s_rdata_bi : 32'h0);
      chk("err_q", dut.err_q, m_err);
      // advance to the state after the coming clock edge
      if (has) void'(m_q.pop_front());
      else if (s_resp_i) m_err = 1;
      if (ack) begin
        m_rr = 1 - g;
        if (wg == 0) m_q.push_back(g);
      end
      m_lock = exp_sreq && !s_ack_i;
      m_owner = g;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m1_req_i = 0; m1_we_i = 0;
    s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
  endtask

  task automatic set_m(input int m, input bit rq, input bit w, input logic [31:0] a);
    if (m == 0) begin
      m0_req_i = rq; m0_we_i = w; m0_addr_bi = a; m0_be_bi = a[3:0]; m0_wdata_bi = ~a;
    end else begin
      m1_req_i = rq; m1_we_i = w; m1_addr_bi = a; m1_be_bi = a[7:4]; m1_wdata_bi = a ^ 32'h5a5a;
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Asserts reset away from a clock edge with busy inputs and checks that
  // every output drops at once.
  task automatic do_reset();
    cyc();
    set_m(0, 1, 0, 32'h10); set_m(1, 1, 1, 32'h20);
    s_ack_i = 1; s_resp_i = 1; s_rdata_bi = 32'hffff_ffff;
    rst_i = 0;
    #1;
    chk("rst_s_req", s_req_o, 0);
    chk("rst_s_addr", s_addr_bo, 0);
    chk("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    chk("rst_resps", {m0_resp_o, m1_resp_o}, 0);
    chk("rst_rdata", m0_rdata_bo | m1_rdata_bo, 0);
    idle();
    repeat (2) @(posedge clk);
    #1 rst_i = 1;
  endtask

  logic [31:0] tbl [4];

  initial begin
    tbl[0] = 32'hA0; tbl[1] = 32'hB1; tbl[2] = 32'hA2; tbl[3] = 32'hB3;

    // 1: contention alternates, responses routed in order
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cyc();
      idle();
      if (c < 4) begin set_m(0, 1, 0, 32'h100 + c); set_m(1, 1, 0, 32'h200 + c); s_ack_i = 1; end
      if (c >= 1) begin s_resp_i = 1; s_rdata_bi = tbl[c-1]; end
      @(negedge clk);
      if (c < 4) begin
        chk("alt_m0_ack", m0_ack_o, (c % 2) == 0);
        chk("alt_m1_ack", m1_ack_o, (c % 2) == 1);
      end
      if (c >= 1) begin
        chk("alt_m0_rdata", m0_rdata_bo, ((c-1) % 2 == 0) ? tbl[c-1] : 32'h0);
        chk("alt_m1_rdata", m1_rdata_bo, ((c-1) % 2 == 1) ? tbl[c-1] : 32'h0);
      end
    end
    $display("test alternation done");

    // 2: grant lock while the slave stalls
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cyc();
      idle();
      set_m(0, 1, 1, 32'h0000_0100); set_m(1, 1, 0, 32'h0000_0200);
      s_ack_i = (c >= 3);
      @(negedge clk);
      if (c <= 3) chk("lock_addr", s_addr_bo, 32'h100);
      if (c == 3) chk("lock_m0_ack", m0_ack_o, 1);
      if (c == 4) begin chk("lock_m1_ack", m1_ack_o, 1); chk("lock_m0_noack", m0_ack_o, 0); end
    end
    $display("test lock done");

    // 3: full tag FIFO masks reads but passes writes
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      idle();
      set_m(0, 1, 0, 32'h300 + c);
      s_ack_i = 1;
      if (c == 4) set_m(1, 1, 1, 32'h400);
      if (c == 6) begin s_resp_i = 1; s_rdata_bi = 32'hC0; end
      @(negedge clk);
      if (c == 4) begin
        chk("full_wr_req", s_req_o, 1); chk("full_wr_we", s_we_o, 1);
        chk("full_m1_ack", m1_ack_o, 1); chk("full_m0_ack", m0_ack_o, 0);
      end
      if (c == 5) chk("full_masked", s_req_o, 0);
      if (c == 6) begin chk("full_pop_masked", s_req_o, 0); chk("full_resp", m0_resp_o, 1); end
      if (c == 7) begin chk("full_reopen", s_req_o, 1); chk("full_reopen_ack", m0_ack_o, 1); end
    end
    $display("test full done");

    // 4: push and pop together at count 2
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cyc();
      idle();
      if (c < 2) begin set_m(1, 1, 0, 32'h500 + c); s_ack_i = 1; end
      if (c == 2) begin set_m(0, 1, 0, 32'h600); s_ack_i = 1; end
      if (c >= 2) begin s_resp_i = 1; s_rdata_bi = 32'h11 * (c - 1); end
      @(negedge clk);
      if (c == 2) begin chk("pp_m1_resp", m1_resp_o, 1); chk("pp_m1_rdata", m1_rdata_bo, 32'h11); chk("pp_m0_ack", m0_ack_o, 1); end
      if (c == 3) chk("pp_m1_rdata2", m1_rdata_bo, 32'h22);
      if (c == 4) chk("pp_m0_rdata", m0_rdata_bo, 32'h33);
      if (c == 5) chk("pp_drop", {m0_resp_o, m1_resp_o}, 0);
    end
    $display("test push_pop done");

    // 5: reset with reads outstanding
    do_reset();
    for (int c = 0; c < 2; c++) begin
      cyc(); idle(); set_m(0, 1, 0, 32'h700 + c); s_ack_i = 1;
    end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(); idle();
      if (c < 2) begin s_resp_i = 1; s_rdata_bi = 32'h55; end
      @(negedge clk);
      if (c < 2) chk("rst_drop", {m0_resp_o, m1_resp_o}, 0);
      if (c == 2) chk("rst_err_q", dut.err_q, 1);
    end
    $display("test reset_flush done");

    // 6: single requester never bubbles
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc(); idle();
      set_m(1, 1, 0, 32'h800 + c); s_ack_i = 1;
      if (c > 0) begin s_resp_i = 1; s_rdata_bi = $urandom; end
      @(negedge clk);
      chk("single_m1_ack", m1_ack_o, 1);
    end
    $display("test single done");

    // 7: randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      set_m(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
      set_m(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
      s_ack_i = ($urandom_range(0, 9) < 7);
      s_resp_i = ($urandom_range(0, 9) < 4);
      s_rdata_bi = $urandom;
      if (c == 1500) do_reset();
    end
    cyc(); idle();
    repeat (2) @(posedge clk);
    $display("test random done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
